// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - RV32I load/store initiator for a word-only data memory port
// Sub-word stores become a read-modify-write because the memory has no byte enables.
module lsu_mem_initiator #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_t;

  state_t      state, state_nxt;
  logic [31:0] rd_q;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        size_bad, acc_b, acc_h, acc_w, zext, illegal, accept, err_now;
  logic [1:0]  off;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] o,
                                          input logic b, input logic h, input logic z);
    logic [7:0]  by;
    logic [15:0] hw;
    case (o)
      2'd0:    by = w[7:0];
      2'd1:    by = w[15:8];
      2'd2:    by = w[23:16];
      default: by = w[31:24];
    endcase
    hw = o[1] ? w[31:16] : w[15:0];
    if (b)      return {{24{by[7] & ~z}}, by};
    else if (h) return {{16{hw[15] & ~z}}, hw};
    else        return w;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] o,
                                        input logic b, input logic h, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (b) begin
      case (o)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (h) begin
      if (o[1]) r[31:16] = d[15:0];
      else      r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Unknown size codes decode as word so the non-checking build always has a defined access.
  always_comb begin
    size_bad = (core_size_i == 3'b011) || (core_size_i[2:1] == 2'b11);
    acc_w    = size_bad || (core_size_i[1:0] == 2'b10);
    acc_h    = !size_bad && (core_size_i[1:0] == 2'b01);
    acc_b    = !size_bad && (core_size_i[1:0] == 2'b00);
    zext     = !size_bad && core_size_i[2];
    illegal  = size_bad || (core_we_i && core_size_i[2]) ||
               (acc_h && core_addr_i[0]) || (acc_w && (core_addr_i[1:0] != 2'b00));
    off      = acc_w ? 2'b00 : (acc_h ? {core_addr_i[1], 1'b0} : core_addr_i[1:0]);
    accept   = core_req_i && !(ALIGN_CHECK && illegal);
    err_now  = ALIGN_CHECK && core_req_i && illegal && (state == IDLE);
  end

  assign load_data  = extract(mem_rd_i, off, acc_b, acc_h, zext);
  assign merge_data = merge(mem_rd_i, off, acc_b, acc_h, core_wd_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!core_we_i)  state_nxt = LOAD_WAIT;
          else if (!acc_w) state_nxt = RMW_WRITE;
        end
      end
      LOAD_WAIT: state_nxt = IDLE;
      RMW_WRITE: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_rd_o    = rd_q;
    core_stall_o = 1'b0;
    core_err_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = {core_addr_i[31:2], 2'b00};
    mem_wd_o     = 32'h0;
    case (state)
      IDLE: begin
        if (err_now) begin
          core_err_o = 1'b1;
        end else if (accept) begin
          mem_req_o    = 1'b1;
          mem_we_o     = core_we_i && acc_w;
          mem_wd_o     = core_wd_i;
          core_stall_o = !(core_we_i && acc_w);
        end
      end
      LOAD_WAIT: core_rd_o = load_data;
      RMW_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        mem_wd_o  = merge_data;
      end
      default: ;
    endcase
    if (rst_i) begin
      core_rd_o    = 32'h0;
      core_stall_o = 1'b0;
      core_err_o   = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = 32'h0;
      mem_wd_o     = 32'h0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   rd_q <= 32'h0;
    else if (state == LOAD_WAIT) rd_q <= load_data;
  end

endmodule
